control_gw_ctrl_to_network_bridge: RTL and testbench

//  Egress stage of the control gateway. It sits between the control block and the network bridge.
//  - Accepts single-beat control messages from the control block.
//  - Emits each one as a two-beat network-bridge packet: a header beat (tlast=0), then the payload beat (tlast=1).
//  - This is the framing that the ingress gateway strips on receive.
//  - Drops malformed (non-tlast) input beats and keeps tx/drop statistics.

---
 rtl/control_gw_ctrl_to_network_bridge.sv | 137 +++++++++++++
 tb/tb_control_gw_ctrl_to_network_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_gw_ctrl_to_network_bridge.sv
// Egress framer: turns each single-beat control message into a header + payload packet for the
// network bridge. Header shows 1 cycle after input acceptance; holds under bridge backpressure.
module control_gw_ctrl_to_network_bridge #(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst,
  input  logic                        from_ctrl_tvalid,
  output logic                        from_ctrl_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  from_ctrl_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  from_ctrl_tkeep,
  input  logic [IP_PORT_WIDTH-1:0]    from_ctrl_tid,
  input  logic [IP_PORT_WIDTH-1:0]    from_ctrl_tdest,
  input  logic [IP_ADDRESS_WIDTH-1:0] from_ctrl_tuser,
  input  logic                        from_ctrl_tlast,
  output logic                        to_network_bridge_tvalid,
  input  logic                        to_network_bridge_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  to_network_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  to_network_bridge_tkeep,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tid,
  output logic [IP_PORT_WIDTH-1:0]    to_network_bridge_tdest,
  output logic [IP_ADDRESS_WIDTH-1:0] to_network_bridge_tuser,
  output logic                        to_network_bridge_tlast,
  output logic [31:0]                 o_tx_count,
  output logic [15:0]                 o_drop_count
);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                      state, state_nxt;
  logic [AXIS_DATA_WIDTH-1:0]  cap_data;
  logic [AXIS_KEEP_WIDTH-1:0]  cap_keep;
  logic [IP_PORT_WIDTH-1:0]    cap_tid;
  logic [IP_PORT_WIDTH-1:0]    cap_tdest;
  logic [IP_ADDRESS_WIDTH-1:0] cap_tuser;
  logic [31:0]                 tx_count_q;
  logic [15:0]                 drop_count_q;
  logic                        running;
  logic                        capture;
  logic                        drop;
  logic                        tx_done;
  logic [15:0]                 keep_bytes;
  logic [AXIS_DATA_WIDTH-1:0]  hdr_data;

  // Holds input ready low for the first cycle after reset, so a reset edge is visible upstream.
  always_comb begin
    state_nxt                = state;
    from_ctrl_tready         = 1'b0;
    to_network_bridge_tvalid = 1'b0;
    to_network_bridge_tlast  = 1'b0;
    capture                  = 1'b0;
    drop                     = 1'b0;
    tx_done                  = 1'b0;
    case (state)
      IDLE: begin
        from_ctrl_tready = running;
        if (running && from_ctrl_tvalid) begin
          if (from_ctrl_tlast) begin
            capture   = 1'b1;
            state_nxt = HDR;
          end else begin
            drop = 1'b1;
          end
        end
      end
      HDR: begin
        to_network_bridge_tvalid = 1'b1;
        if (to_network_bridge_tready) state_nxt = PAY;
      end
      PAY: begin
        to_network_bridge_tvalid = 1'b1;
        to_network_bridge_tlast  = 1'b1;
        from_ctrl_tready         = to_network_bridge_tready;
        if (to_network_bridge_tready) begin
          tx_done   = 1'b1;
          state_nxt = IDLE;
          if (from_ctrl_tvalid) begin
            if (from_ctrl_tlast) begin
              capture   = 1'b1;
              state_nxt = HDR;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    keep_bytes = 16'd0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) keep_bytes = keep_bytes + 16'(cap_keep[i]);
    hdr_data        = '0;
    hdr_data[15:0]  = keep_bytes;
    hdr_data[31:16] = cap_tdest;
    hdr_data[63:32] = cap_tuser;
  end

  assign to_network_bridge_tdata = (state == HDR) ? hdr_data : cap_data;
  assign to_network_bridge_tkeep = (state == HDR) ? {AXIS_KEEP_WIDTH{1'b1}} : cap_keep;
  assign to_network_bridge_tid   = cap_tid;
  assign to_network_bridge_tdest = cap_tdest;
  assign to_network_bridge_tuser = cap_tuser;
  assign o_tx_count              = tx_count_q;
  assign o_drop_count            = drop_count_q;

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state        <= IDLE;
      running      <= 1'b0;
      cap_data     <= '0;
      cap_keep     <= '0;
      cap_tid      <= '0;
      cap_tdest    <= '0;
      cap_tuser    <= '0;
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state   <= state_nxt;
      running <= 1'b1;
      if (capture) begin
        cap_data  <= from_ctrl_tdata;
        cap_keep  <= from_ctrl_tkeep;
        cap_tid   <= from_ctrl_tid;
        cap_tdest <= from_ctrl_tdest;
        cap_tuser <= from_ctrl_tuser;
      end
      if (tx_done) tx_count_q <= tx_count_q + 32'd1;
      if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_control_gw_ctrl_to_network_bridge.sv
// Scoreboard bench: accepted messages expand into expected header/payload beats that a negedge
// monitor pops and compares; counters, stall stability and ready rules are checked every cycle.
module tb_control_gw_ctrl_to_network_bridge;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [15:0] tid;
    logic [15:0] tdest;
    logic [31:0] tuser;
    logic        last;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_ap_rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic [15:0] in_tid = '0;
  logic [15:0] in_tdest = '0;
  logic [31:0] in_tuser = '0;
  logic        in_last = 1'b0;
  logic        nb_vld;
  logic        nb_rdy = 1'b0;
  logic [63:0] nb_data;
  logic [7:0]  nb_keep;
  logic [15:0] nb_tid;
  logic [15:0] nb_tdest;
  logic [31:0] nb_tuser;
  logic        nb_last;
  logic [31:0] tx_count;
  logic [15:0] drop_count;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rdy_mode = 2;  // 0: always ready, 1: random, 2: scripted by stimulus
  bit    started = 0;
  bit    exp_rst_state = 0;
  bit    prev_stall = 0;
  bit    acc_prev_last = 0;
  beat_t exp_q[$];
  int    beat_cyc_q[$];
  beat_t prev_out;
  logic [63:0] last_hdr = '0;
  logic [31:0] exp_tx = '0;
  logic [15:0] exp_drop = '0;

  control_gw_ctrl_to_network_bridge dut (
    .i_clk(i_clk), .i_ap_rst(i_ap_rst),
    .from_ctrl_tvalid(in_vld), .from_ctrl_tready(in_rdy), .from_ctrl_tdata(in_data),
    .from_ctrl_tkeep(in_keep), .from_ctrl_tid(in_tid), .from_ctrl_tdest(in_tdest),
    .from_ctrl_tuser(in_tuser), .from_ctrl_tlast(in_last),
    .to_network_bridge_tvalid(nb_vld), .to_network_bridge_tready(nb_rdy),
    .to_network_bridge_tdata(nb_data), .to_network_bridge_tkeep(nb_keep),
    .to_network_bridge_tid(nb_tid), .to_network_bridge_tdest(nb_tdest),
    .to_network_bridge_tuser(nb_tuser), .to_network_bridge_tlast(nb_last),
    .o_tx_count(tx_count), .o_drop_count(drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    if (rdy_mode == 0) nb_rdy = 1'b1;
    else if (rdy_mode == 1) nb_rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor / scoreboard.
  always @(negedge i_clk) begin
    beat_t cur;
    beat_t e;
    cyc++;
    if (started) begin
      cur = '{nb_data, nb_keep, nb_tid, nb_tdest, nb_tuser, nb_last};
      if (exp_rst_state) begin
        chk("rst_out_valid", 64'(nb_vld), 64'd0);
        chk("rst_in_ready", 64'(in_rdy), 64'd0);
        exp_rst_state = 0;
      end
      chk("tx_count", 64'(tx_count), 64'(exp_tx));
      chk("drop_count", 64'(drop_count), 64'(exp_drop));
      if (prev_stall) begin
        chk("stall_valid", 64'(nb_vld), 64'd1);
        chk("stall_data", cur.data, prev_out.data);
        chk("stall_side", {cur.keep, cur.tid, cur.tdest, cur.last},
            {prev_out.keep, prev_out.tid, prev_out.tdest, prev_out.last});
        chk("stall_user", 64'(cur.tuser), 64'(prev_out.tuser));
      end
      if (nb_vld && !nb_last) chk("hdr_in_ready", 64'(in_rdy), 64'd0);
      if (nb_vld && nb_last) chk("pay_in_ready", 64'(in_rdy), 64'(nb_rdy));
      if (acc_prev_last) chk("hdr_latency", 64'(nb_vld && !nb_last), 64'd1);
      if (i_ap_rst) begin
        exp_q.delete();
        exp_tx = '0;
        exp_drop = '0;
        exp_rst_state = 1;
        prev_stall = 0;
        acc_prev_last = 0;
      end else begin
        if (nb_vld && nb_rdy) begin
          beat_cyc_q.push_back(cyc);
          if (!nb_last) last_hdr = nb_data;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", cur.data, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", cur.data, e.data);
            chk("beat_keep_last", {cur.keep, cur.last}, {e.keep, e.last});
            chk("beat_ids", {cur.tuser, cur.tdest, cur.tid}, {e.tuser, e.tdest, e.tid});
            if (e.last) exp_tx = exp_tx + 32'd1;
          end
        end
        acc_prev_last = 0;
        if (in_vld && in_rdy) begin
          if (in_last) begin
            exp_q.push_back('{{in_tuser, in_tdest, 16'($countones(in_keep))}, 8'hFF,
                              in_tid, in_tdest, in_tuser, 1'b0});
            exp_q.push_back('{in_data, in_keep, in_tid, in_tdest, in_tuser, 1'b1});
            acc_prev_last = 1;
          end else if (exp_drop != 16'hFFFF) begin
            exp_drop = exp_drop + 16'd1;
          end
        end
        prev_stall = nb_vld && !nb_rdy;
        prev_out = cur;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic [15:0] id,
                            input logic [15:0] dst, input logic [31:0] u, input logic l);
    bit ok = 0;
    in_vld = 1'b1; in_data = d; in_keep = k; in_tid = id; in_tdest = dst; in_tuser = u; in_last = l;
    for (int n = 0; n < 1000; n++) begin
      @(negedge i_clk);
      if (in_rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL in_accept_timeout");
    end
    @(posedge i_clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drive_rand(input logic l);
    drive_beat({$urandom, $urandom}, 8'($urandom), 16'($urandom), 16'($urandom), $urandom, l);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !nb_vld) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats outstanding", exp_q.size());
    end
    @(posedge i_clk); #1;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  initial begin
    step(1);
    started = 1;
    step(2);
    i_ap_rst = 1'b0;
    step(1);
    chk("reset_tx", 64'(tx_count), 64'd0);

    // Single message.
    rdy_mode = 0;
    drive_beat(64'h1122334455667788, 8'hFF, 16'h0007, 16'h1F90, 32'h0A000001, 1'b1);
    wait_drain();
    chk("t1_header", last_hdr, 64'h0A0000011F900008);
    chk("t1_tx", 64'(tx_count), 64'd1);

    // Backpressure: 5 stalled cycles on header, 3 on payload.
    rdy_mode = 2; nb_rdy = 1'b0;
    beat_cyc_q.delete();
    drive_rand(1'b1);
    step(5); nb_rdy = 1'b1;
    step(1); nb_rdy = 1'b0;
    step(3); nb_rdy = 1'b1;
    step(1); rdy_mode = 0;
    wait_drain();
    chk("t2_beats", 64'(beat_cyc_q.size()), 64'd2);

    // Back-to-back messages at full rate.
    beat_cyc_q.delete();
    for (int i = 0; i < 4; i++) drive_rand(1'b1);
    wait_drain();
    chk("t3_beats", 64'(beat_cyc_q.size()), 64'd8);
    if (beat_cyc_q.size() == 8) chk("t3_span", 64'(beat_cyc_q[7] - beat_cyc_q[0]), 64'd7);
    chk("t3_tx", 64'(tx_count), 64'd6);

    // Malformed beat then a short message.
    drive_rand(1'b0);
    drive_beat(64'hCAFE, 8'h0F, 16'h1, 16'h2, 32'h3, 1'b1);
    wait_drain();
    chk("t4_drop", 64'(drop_count), 64'd1);
    chk("t4_hdr_len", 64'(last_hdr[15:0]), 64'd4);

    // Reset right after the header handshake.
    rdy_mode = 2; nb_rdy = 1'b1;
    drive_rand(1'b1);
    begin
      bit seen = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge i_clk);
        if (nb_vld && nb_rdy && !nb_last) begin seen = 1; break; end
      end
      chk("t5_hdr_seen", 64'(seen), 64'd1);
    end
    @(posedge i_clk); #1;
    i_ap_rst = 1'b1;
    step(1);
    i_ap_rst = 1'b0;
    step(1);
    rdy_mode = 0;
    drive_rand(1'b1);
    wait_drain();
    chk("t5_tx", 64'(tx_count), 64'd1);

    // Counter limits.
    step(1);
    force dut.drop_count_q = 16'hFFFF;
    exp_drop = 16'hFFFF;
    #1 release dut.drop_count_q;
    step(1);
    drive_rand(1'b0);
    step(1);
    chk("t6_drop_sat", 64'(drop_count), 64'hFFFF);
    force dut.tx_count_q = 32'hFFFF_FFFF;
    exp_tx = 32'hFFFF_FFFF;
    #1 release dut.tx_count_q;
    step(1);
    drive_rand(1'b1);
    wait_drain();
    chk("t6_tx_wrap", 64'(tx_count), 64'd0);

    // Randomized traffic with random bridge backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2));
      drive_rand($urandom_range(0, 6) != 0);
    end
    rdy_mode = 0;
    wait_drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
